// File: rtl/brg_hcc_ctrl_pkg.sv
// Shared types and helpers for the freeze/drain controller.
// Covers channel state encoding, CSR offsets and STATUS field packing.
package brg_hcc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_FROZEN = 2'd2
   } ctrl_state_e;

   localparam int STATUS_W         = 16;
   localparam int STATUS_STATE_LSB = 0;
   localparam int STATUS_ERR_BIT   = 2;
   localparam int STATUS_CNT_LSB   = 8;
   localparam int STATUS_CNT_W     = 8;

   function automatic int freeze_offset(input int ch);
      return ch;
   endfunction

   function automatic int status_offset(input int num_ch, input int ch);
      return num_ch + ch;
   endfunction

   function automatic logic [STATUS_W-1:0] pack_status(input logic [1:0]              state,
                                                       input logic                    err,
                                                       input logic [STATUS_CNT_W-1:0] cnt);
      logic [STATUS_W-1:0] s;
      s = '0;
      s[STATUS_STATE_LSB +: 2]           = state;
      s[STATUS_ERR_BIT]                  = err;
      s[STATUS_CNT_LSB +: STATUS_CNT_W]  = cnt;
      return s;
   endfunction

endpackage

// File: rtl/brg_hcc_ctrl_channel.sv
// One channel of the freeze/drain controller: state machine, outstanding
// counter with sticky underflow flag, and request/ready gating.
module brg_hcc_ctrl_channel
   import brg_hcc_ctrl_pkg::*;
#(
   parameter int max_out_p = 16,
   parameter int cnt_w     = $clog2(max_out_p + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             freeze_we_i,
   input  logic             freeze_val_i,
   input  logic             out_v_i,
   input  logic             out_ready_i,
   input  logic             resp_v_i,
   output logic             out_v_o,
   output logic             out_ready_o,
   output logic             freeze_o,
   output logic [1:0]       state_o,
   output logic [cnt_w-1:0] cnt_o,
   output logic             err_o
);

   localparam logic [1:0]       S_RUN    = ST_RUN;
   localparam logic [1:0]       S_DRAIN  = ST_DRAIN;
   localparam logic [1:0]       S_FROZEN = ST_FROZEN;
   localparam logic [cnt_w-1:0] CNT_MAX  = cnt_w'(max_out_p);

   logic [1:0]       state, state_n;
   logic [cnt_w-1:0] cnt, cnt_n;
   logic             err, err_n;
   logic             blocked, fire;

   assign blocked     = (state != S_RUN) || (cnt == CNT_MAX);
   assign out_v_o     = out_v_i & ~blocked;
   assign out_ready_o = out_ready_i & ~blocked;
   assign fire        = out_v_o & out_ready_i;
   assign freeze_o    = (state == S_FROZEN);
   assign state_o     = state;
   assign cnt_o       = cnt;
   assign err_o       = err;

   // A simultaneous issue and response cancel; a lone response at zero is an underflow.
   always_comb begin
      cnt_n = cnt;
      err_n = err;
      if (fire && !resp_v_i) begin
         cnt_n = cnt + cnt_w'(1);
      end else if (!fire && resp_v_i) begin
         if (cnt == '0) err_n = 1'b1;
         else           cnt_n = cnt - cnt_w'(1);
      end
   end

   // An unfreeze write takes priority over drain completion in the same cycle.
   always_comb begin
      state_n = state;
      case (state)
         S_RUN: begin
            if (freeze_we_i && freeze_val_i) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            if (freeze_we_i && !freeze_val_i) state_n = S_RUN;
            else if (cnt == '0)               state_n = S_FROZEN;
         end
         S_FROZEN: begin
            if (freeze_we_i && !freeze_val_i) state_n = S_RUN;
         end
         default: state_n = S_FROZEN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= S_FROZEN;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         err   <= err_n;
      end
   end

endmodule

// File: rtl/brg_hcc_ctrl_unit.sv
// Multi-channel freeze/drain controller: CSR window decode on the slave
// path, one-cycle response register and per-channel gating instances.
module brg_hcc_ctrl_unit
   import brg_hcc_ctrl_pkg::*;
#(
   parameter int num_ch_p     = 2,
   parameter int addr_width_p = 32,
   parameter int data_width_p = 32,
   parameter int max_out_p    = 16,
   parameter int csr_base_p   = 'h100
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    in_v_i,
   input  logic                    in_we_i,
   input  logic [addr_width_p-1:0] in_addr_i,
   input  logic [data_width_p-1:0] in_data_i,
   output logic                    in_yumi_o,
   output logic                    returning_v_o,
   output logic [data_width_p-1:0] returning_data_o,
   input  logic [num_ch_p-1:0]     out_v_i,
   input  logic [num_ch_p-1:0]     out_ready_i,
   output logic [num_ch_p-1:0]     out_v_o,
   output logic [num_ch_p-1:0]     out_ready_o,
   input  logic [num_ch_p-1:0]     resp_v_i,
   output logic [num_ch_p-1:0]     freeze_o,
   output logic                    all_frozen_o
);

   localparam int                      cnt_w = $clog2(max_out_p + 1);
   localparam logic [addr_width_p-1:0] BASE  = addr_width_p'(csr_base_p);
   localparam logic [addr_width_p-1:0] WIN   = addr_width_p'(2 * num_ch_p);

   logic [addr_width_p-1:0] off_p0;
   logic                    hit_p0;
   logic [data_width_p-1:0] rdata_p0;
   logic [num_ch_p-1:0]     freeze_we;
   logic [1:0]              state [num_ch_p];
   logic [cnt_w-1:0]        cnt   [num_ch_p];
   logic [num_ch_p-1:0]     err;
   logic                    resp_v_p1;
   logic [data_width_p-1:0] resp_data_p1;
   logic                    unused_data;

   // Only bit 0 of store data is meaningful for FREEZE writes.
   assign unused_data = ^in_data_i[data_width_p-1:1];

   // Stage p0: window decode and STATUS read mux at acceptance.
   assign off_p0    = in_addr_i - BASE;
   assign hit_p0    = (in_addr_i >= BASE) && (off_p0 < WIN);
   assign in_yumi_o = in_v_i & hit_p0;

   always_comb begin
      rdata_p0 = '0;
      for (int k = 0; k < num_ch_p; k++) begin
         if (!in_we_i && off_p0 == addr_width_p'(status_offset(num_ch_p, k))) begin
            rdata_p0 = data_width_p'(pack_status(state[k], err[k], STATUS_CNT_W'(cnt[k])));
         end
      end
   end

   for (genvar k = 0; k < num_ch_p; k++) begin : g_ch
      assign freeze_we[k] = in_yumi_o & in_we_i &
                            (off_p0 == addr_width_p'(freeze_offset(k)));

      brg_hcc_ctrl_channel #(
         .max_out_p (max_out_p),
         .cnt_w     (cnt_w)
      ) u_ch (
         .clk_i        (clk_i),
         .reset_i      (reset_i),
         .freeze_we_i  (freeze_we[k]),
         .freeze_val_i (in_data_i[0]),
         .out_v_i      (out_v_i[k]),
         .out_ready_i  (out_ready_i[k]),
         .resp_v_i     (resp_v_i[k]),
         .out_v_o      (out_v_o[k]),
         .out_ready_o  (out_ready_o[k]),
         .freeze_o     (freeze_o[k]),
         .state_o      (state[k]),
         .cnt_o        (cnt[k]),
         .err_o        (err[k])
      );
   end

   assign all_frozen_o = &freeze_o;

   // Stage p1: response register, exactly one cycle after acceptance.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_v_p1    <= 1'b0;
         resp_data_p1 <= '0;
      end else begin
         resp_v_p1    <= in_yumi_o;
         resp_data_p1 <= in_yumi_o ? rdata_p0 : '0;
      end
   end

   assign returning_v_o    = resp_v_p1;
   assign returning_data_o = resp_data_p1;

endmodule

// File: tb/tb_brg_hcc_ctrl_unit.sv
// Directed bench for brg_hcc_ctrl_unit (num_ch_p=2, max_out_p=16, CSR base 0x100).
module tb_brg_hcc_ctrl_unit;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        in_v_i = 1'b0;
   logic        in_we_i = 1'b0;
   logic [31:0] in_addr_i = '0;
   logic [31:0] in_data_i = '0;
   logic        in_yumi_o;
   logic        returning_v_o;
   logic [31:0] returning_data_o;
   logic [1:0]  out_v_i = '0;
   logic [1:0]  out_ready_i = '0;
   logic [1:0]  out_v_o;
   logic [1:0]  out_ready_o;
   logic [1:0]  resp_v_i = '0;
   logic [1:0]  freeze_o;
   logic        all_frozen_o;

   int n_chk = 0;
   int n_err = 0;

   logic        yumi, rv;
   logic [31:0] rd;

   always #5 clk = ~clk;

   brg_hcc_ctrl_unit #(
      .num_ch_p     (2),
      .addr_width_p (32),
      .data_width_p (32),
      .max_out_p    (16),
      .csr_base_p   ('h100)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .in_v_i           (in_v_i),
      .in_we_i          (in_we_i),
      .in_addr_i        (in_addr_i),
      .in_data_i        (in_data_i),
      .in_yumi_o        (in_yumi_o),
      .returning_v_o    (returning_v_o),
      .returning_data_o (returning_data_o),
      .out_v_i          (out_v_i),
      .out_ready_i      (out_ready_i),
      .out_v_o          (out_v_o),
      .out_ready_o      (out_ready_o),
      .resp_v_i         (resp_v_i),
      .freeze_o         (freeze_o),
      .all_frozen_o     (all_frozen_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic csr(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      output logic y, output logic v, output logic [31:0] d);
      in_v_i = 1'b1; in_we_i = we; in_addr_i = addr; in_data_i = data;
      #1 y = in_yumi_o;
      tick();
      in_v_i = 1'b0; in_we_i = 1'b0;
      #1 v = returning_v_o;
      d = returning_data_o;
   endtask

   task automatic wr_freeze(input int ch, input logic [31:0] val);
      logic y, v;
      logic [31:0] d;
      csr(1'b1, 32'h100 + 32'(ch), val, y, v, d);
      check("wr_yumi", {31'd0, y}, 32'd1);
      check("wr_resp", {31'd0, v}, 32'd1);
      check("wr_data", d, 32'd0);
   endtask

   task automatic rd_status(input int ch, input logic [31:0] exp, input string tag);
      logic y, v;
      logic [31:0] d;
      csr(1'b0, 32'h102 + 32'(ch), 32'd0, y, v, d);
      check({tag, "_v"}, {31'd0, v}, 32'd1);
      check(tag, d, exp);
   endtask

   initial begin
      // Reset: everything frozen, gating closed even with requests pending.
      out_v_i = 2'b11; out_ready_i = 2'b11;
      tick(); tick();
      #1;
      check("rst_freeze", {30'd0, freeze_o}, 32'h3);
      check("rst_allfrz", {31'd0, all_frozen_o}, 32'h1);
      check("rst_outv", {30'd0, out_v_o}, 32'h0);
      check("rst_outrdy", {30'd0, out_ready_o}, 32'h0);
      check("rst_retv", {31'd0, returning_v_o}, 32'h0);
      check("rst_retd", returning_data_o, 32'h0);
      out_v_i = 2'b00;
      reset_i = 1'b0;
      tick();

      // Load STATUS[0] after reset.
      csr(1'b0, 32'h102, 32'd0, yumi, rv, rd);
      check("st0_yumi", {31'd0, yumi}, 32'h1);
      check("st0_rv", {31'd0, rv}, 32'h1);
      check("st0_data", rd, 32'h2);

      // Unfreeze ch0, issue 3 requests.
      wr_freeze(0, 32'd0);
      check("run_freeze", {30'd0, freeze_o}, 32'h2);
      check("run_allfrz", {31'd0, all_frozen_o}, 32'h0);
      out_v_i = 2'b01;
      #1 check("run_outv", {30'd0, out_v_o}, 32'h1);
      repeat (3) tick();
      out_v_i = 2'b00;
      rd_status(0, 32'h0300, "cnt3");

      // Freeze ch0 -> DRAIN, gating closed.
      wr_freeze(0, 32'd1);
      rd_status(0, 32'h0301, "drain3");
      out_v_i = 2'b01;
      #1 check("drain_outv", {30'd0, out_v_o}, 32'h0);
      check("drain_outrdy", {30'd0, out_ready_o}, 32'h0);
      out_v_i = 2'b00;

      // Three responses; FROZEN the cycle after the count hits zero.
      resp_v_i = 2'b01;
      repeat (3) tick();
      resp_v_i = 2'b00;
      #1 check("cnt0_still_drain", {31'd0, freeze_o[0]}, 32'h0);
      tick();
      #1 check("frozen_after", {31'd0, freeze_o[0]}, 32'h1);
      rd_status(0, 32'h0002, "frozen0");

      // Fill ch0 to the outstanding limit.
      wr_freeze(0, 32'd0);
      out_v_i = 2'b01;
      repeat (16) tick();
      #1 check("full_outv", {30'd0, out_v_o}, 32'h0);
      check("full_outrdy", {31'd0, out_ready_o[0]}, 32'h0);
      resp_v_i = 2'b01;
      tick();
      resp_v_i = 2'b00;
      #1 check("unblock_outv", {30'd0, out_v_o}, 32'h1);
      resp_v_i = 2'b01;
      tick();
      resp_v_i = 2'b00;
      out_v_i = 2'b00;
      rd_status(0, 32'h0F00, "both_same");
      out_v_i = 2'b01;
      tick();
      out_v_i = 2'b00;
      rd_status(0, 32'h1000, "refill16");

      // Bring count to 5 and start draining.
      resp_v_i = 2'b01;
      repeat (11) tick();
      resp_v_i = 2'b00;
      wr_freeze(0, 32'd1);
      rd_status(0, 32'h0501, "drain5");

      // Underflow on idle ch1.
      resp_v_i = 2'b10;
      tick();
      resp_v_i = 2'b00;
      rd_status(1, 32'h0006, "underflow");

      // Reset mid-drain with a CSR load accepted in the same cycle.
      in_v_i = 1'b1; in_we_i = 1'b0; in_addr_i = 32'h102;
      reset_i = 1'b1;
      tick();
      in_v_i = 1'b0;
      #1 check("rst_drop_retv", {31'd0, returning_v_o}, 32'h0);
      check("rst_mid_freeze", {30'd0, freeze_o}, 32'h3);
      reset_i = 1'b0;
      rd_status(0, 32'h0002, "rst_st0");
      rd_status(1, 32'h0002, "rst_err_clr");

      // Abort a drain on ch1.
      wr_freeze(1, 32'd0);
      out_v_i = 2'b10;
      repeat (2) tick();
      out_v_i = 2'b00;
      wr_freeze(1, 32'd1);
      rd_status(1, 32'h0201, "drain1");
      wr_freeze(1, 32'd0);
      rd_status(1, 32'h0200, "abort1");
      check("abort_freeze", {31'd0, freeze_o[1]}, 32'h0);

      // Address just past the window is not consumed.
      csr(1'b0, 32'h104, 32'd0, yumi, rv, rd);
      check("miss_yumi", {31'd0, yumi}, 32'h0);
      check("miss_rv", {31'd0, rv}, 32'h0);

      // Store to STATUS and load from FREEZE have no effect and return 0.
      csr(1'b1, 32'h102, 32'hFFFF, yumi, rv, rd);
      check("st_wr_rv", {31'd0, rv}, 32'h1);
      check("st_wr_d", rd, 32'h0);
      rd_status(0, 32'h0002, "st_wr_noeff");
      csr(1'b0, 32'h100, 32'd0, yumi, rv, rd);
      check("frz_rd_rv", {31'd0, rv}, 32'h1);
      check("frz_rd_d", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
